mem_access_stage: RTL and testbench
===================================

Name: mem_access_stage

Overview:
Memory-access pipeline stage sitting directly upstream of the write-back stage. It takes the execute result and controls, performs data-memory loads and stores with configurable wait-state latency, and registers ALU result, load data, destination register and write-back controls for write-back. A stall flag back-pressures execute while a multi-cycle access is in flight.

Parameters:
DEPTH, 256, data-memory size in 32-bit words; power of two.
ADDR_W, 8, word-index width; equals log2(DEPTH).
MEM_LATENCY, 2, cycles per load/store from accept edge to completion edge; legal range 1..15.

Ports:
clk  in  1  clock; all state updates on posedge
reset  in  1  synchronous, active-high reset
ex_valid  in  1  execute presents a real instruction (0 = bubble)
alu_result_in  in  32  ALU result; byte address for loads/stores
rs2_data_in  in  32  store data
rd_in  in  5  destination register
reg_write_in  in  1  register-write enable
mem_to_reg_in  in  1  write-back selects load data
mem_read_in  in  1  load
mem_write_in  in  1  store
stall_flag_mem_in  in  1  downstream (write-back) stall request
alu_data_out  out  32  registered ALU result
dm_data_out  out  32  registered load data
rd_out_mem  out  5  registered destination register
reg_write_out_mem  out  1  registered register-write enable
mem_to_reg_out  out  1  registered mem_to_reg
wb_valid  out  1  output bundle holds a newly completed instruction
stall_flag_mem_out  out  1  upstream must hold inputs stable

Behaviour:
- Reset, on a posedge with reset=1: all outputs 0; FSM to IDLE; wait counter 0. Memory contents unchanged.
- Reset mid-access aborts it. An uncommitted store is never written.
- FSM states are IDLE and WAIT. stall_flag_mem_out = (state==WAIT) | stall_flag_mem_in, combinational.
- Hold: if stall_flag_mem_in=1, nothing is accepted. Outputs and FSM hold, and wb_valid holds its value.
- IDLE, ex_valid=0: wb_valid<=0, reg_write_out_mem<=0. Other outputs hold.
- IDLE, non-memory instruction: at the accept edge, register alu/rd/controls and set wb_valid<=1. dm_data_out<=0. Latency 1.
- IDLE, load or store with MEM_LATENCY=1: completes at the accept edge, same as a non-memory instruction.
- IDLE, load or store with MEM_LATENCY>1:
  - Accept edge: capture inputs internally, go to WAIT, cnt<=MEM_LATENCY-1, wb_valid<=0.
  - Each WAIT edge: cnt decrements.
  - Edge with cnt==1: complete, return to IDLE, wb_valid<=1.
  - Completion edge = accept edge + (MEM_LATENCY-1).
- Completion:
  - Word index = addr[ADDR_W+1:2]. Upper bits are ignored, so addresses wrap modulo DEPTH.
  - Load: dm_data_out<=mem[index].
  - Store: mem[index]<=rs2_data; dm_data_out<=0.
- mem_read_in and mem_write_in both 1: treated as a store; dm_data_out<=0.
- A load immediately after a store to the same word returns the new data.
- reg_write and mem_to_reg pass through unmodified; the control unit guarantees reg_write=0 for stores.
- In WAIT, stall_flag_mem_in=1 freezes cnt.
- wb_valid is high for exactly one unstalled cycle per instruction.

Optional Feature:
Macro MEM_MISALIGN_CHECK_EN.
- Defined:
  - A load or store with addr[1:0]!=0 completes on schedule with no memory write.
  - dm_data_out<=0 and reg_write_out_mem<=0.
  - Extra output port misalign_out (1 bit) is pulsed high with wb_valid; it resets to 0.
- Undefined: addr[1:0] are ignored and there is no misalign_out port.

Decomposition:
- Package mem_stage_pkg: WORD_W=32, REG_ADDR_W=5, enum mem_state_t {IDLE, WAIT}, latency-counter width constant (4).
- Sub-module dmem_array: single-port synchronous RAM (DEPTH x 32), with write enable, word index, write data and registered read data. No reset.
- The stage instantiates dmem_array once and owns the FSM, counter and output registers.

Test Plan:
- Reset: hold reset 2 cycles mid-WAIT of a store to 0x10, then load 0x10 -> all outputs 0 after reset; the load returns the prior contents (store aborted).
- ALU op: rd=5, alu=0xDEADBEEF, reg_write=1, MEM_LATENCY=3 -> next edge alu_data_out=0xDEADBEEF, rd_out_mem=5, wb_valid=1, stall never asserted.
- Store then load, MEM_LATENCY=3:
  - store 0x12345678 to addr 0x40 -> stall_flag_mem_out high 2 cycles, then wb_valid.
  - load 0x40 -> dm_data_out=0x12345678 after 2 stall cycles.
- Wrap: store 0xA5 to addr 4*DEPTH+8, load addr 8 -> dm_data_out=0xA5.
- Downstream stall: assert stall_flag_mem_in for 3 cycles during WAIT -> cnt frozen, outputs held, completion delayed exactly 3 cycles.
- MEM_MISALIGN_CHECK_EN: load addr 0x42 with reg_write=1 -> misalign_out=1, reg_write_out_mem=0, dm_data_out=0.

Source files
------------

// File: rtl/mem_stage_pkg.sv
// Shared types and widths for the memory-access pipeline stage.
package mem_stage_pkg;
  localparam int WORD_W     = 32;
  localparam int REG_ADDR_W = 5;
  localparam int CNT_W      = 4;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } mem_state_t;
endpackage

// File: rtl/dmem_array.sv
// Single-port synchronous data RAM with registered read data; no reset on
// contents or read register. Read register updates only when re is high.
module dmem_array
  import mem_stage_pkg::*;
#(
  parameter int DEPTH  = 256,
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              we,
  input  logic              re,
  input  logic [ADDR_W-1:0] idx,
  input  logic [WORD_W-1:0] wdata,
  output logic [WORD_W-1:0] q
);
  logic [WORD_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[idx] <= wdata;
    if (re) q <= mem[idx];
  end
endmodule

// File: rtl/mem_access_stage.sv
// Memory-access stage: loads/stores with MEM_LATENCY wait states, registered
// write-back bundle. Optional macro MEM_MISALIGN_CHECK_EN adds misalign_out.
module mem_access_stage
  import mem_stage_pkg::*;
#(
  parameter int DEPTH       = 256,
  parameter int ADDR_W      = 8,
  parameter int MEM_LATENCY = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  ex_valid,
  input  logic [WORD_W-1:0]     alu_result_in,
  input  logic [WORD_W-1:0]     rs2_data_in,
  input  logic [REG_ADDR_W-1:0] rd_in,
  input  logic                  reg_write_in,
  input  logic                  mem_to_reg_in,
  input  logic                  mem_read_in,
  input  logic                  mem_write_in,
  input  logic                  stall_flag_mem_in,
  output logic [WORD_W-1:0]     alu_data_out,
  output logic [WORD_W-1:0]     dm_data_out,
  output logic [REG_ADDR_W-1:0] rd_out_mem,
  output logic                  reg_write_out_mem,
  output logic                  mem_to_reg_out,
  output logic                  wb_valid,
  output logic                  stall_flag_mem_out
`ifdef MEM_MISALIGN_CHECK_EN
  ,
  output logic                  misalign_out
`endif
);
  localparam bit SINGLE_CYCLE = (MEM_LATENCY == 1);
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(MEM_LATENCY - 1);

  mem_state_t            state;
  logic [CNT_W-1:0]      cnt;
  logic                  load_sel;

  logic [WORD_W-1:0]     cap_alu, cap_rs2;
  logic [REG_ADDR_W-1:0] cap_rd;
  logic                  cap_rw, cap_m2r, cap_rd_en, cap_wr;

  logic [WORD_W-1:0]     cur_alu, cur_rs2;
  logic [REG_ADDR_W-1:0] cur_rd;
  logic                  cur_rw, cur_m2r, cur_rd_en, cur_wr, cur_mem;
  logic                  is_store, is_load, mis, complete;
  logic                  mem_we, mem_re;
  logic [WORD_W-1:0]     ram_q;
  logic                  unused_bits;

  // In WAIT the captured instruction is the one being completed.
  always_comb begin
    cur_alu   = alu_result_in;
    cur_rs2   = rs2_data_in;
    cur_rd    = rd_in;
    cur_rw    = reg_write_in;
    cur_m2r   = mem_to_reg_in;
    cur_rd_en = mem_read_in;
    cur_wr    = mem_write_in;
    if (state == WAIT) begin
      cur_alu   = cap_alu;
      cur_rs2   = cap_rs2;
      cur_rd    = cap_rd;
      cur_rw    = cap_rw;
      cur_m2r   = cap_m2r;
      cur_rd_en = cap_rd_en;
      cur_wr    = cap_wr;
    end
  end

  assign cur_mem  = cur_rd_en | cur_wr;
  assign is_store = cur_wr;
  assign is_load  = cur_rd_en & ~cur_wr;

`ifdef MEM_MISALIGN_CHECK_EN
  assign mis = cur_mem & (cur_alu[1:0] != 2'b00);
`else
  assign mis = 1'b0;
`endif

  assign complete = ~stall_flag_mem_in &
                    (((state == IDLE) & ex_valid & (~cur_mem | SINGLE_CYCLE)) |
                     ((state == WAIT) & (cnt == CNT_W'(1))));

  // Reset gating guarantees an aborted store never reaches the array.
  assign mem_we = complete & is_store & ~mis & ~reset;
  assign mem_re = complete & is_load  & ~mis & ~reset;

  assign stall_flag_mem_out = (state == WAIT) | stall_flag_mem_in;
  assign dm_data_out        = load_sel ? ram_q : '0;
  assign unused_bits        = ^{cur_alu[WORD_W-1:ADDR_W+2], cur_alu[1:0]};

  dmem_array #(
    .DEPTH (DEPTH),
    .ADDR_W(ADDR_W)
  ) u_dmem (
    .clk  (clk),
    .we   (mem_we),
    .re   (mem_re),
    .idx  (cur_alu[ADDR_W+1:2]),
    .wdata(cur_rs2),
    .q    (ram_q)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state             <= IDLE;
      cnt               <= '0;
      load_sel          <= 1'b0;
      alu_data_out      <= '0;
      rd_out_mem        <= '0;
      reg_write_out_mem <= 1'b0;
      mem_to_reg_out    <= 1'b0;
      wb_valid          <= 1'b0;
      cap_alu           <= '0;
      cap_rs2           <= '0;
      cap_rd            <= '0;
      cap_rw            <= 1'b0;
      cap_m2r           <= 1'b0;
      cap_rd_en         <= 1'b0;
      cap_wr            <= 1'b0;
    end else if (!stall_flag_mem_in) begin
      if (complete) begin
        state             <= IDLE;
        cnt               <= '0;
        alu_data_out      <= cur_alu;
        rd_out_mem        <= cur_rd;
        reg_write_out_mem <= cur_rw & ~mis;
        mem_to_reg_out    <= cur_m2r;
        load_sel          <= is_load & ~mis;
        wb_valid          <= 1'b1;
      end else begin
        case (state)
          IDLE: begin
            wb_valid <= 1'b0;
            if (!ex_valid) begin
              reg_write_out_mem <= 1'b0;
            end else begin
              state     <= WAIT;
              cnt       <= CNT_INIT;
              cap_alu   <= alu_result_in;
              cap_rs2   <= rs2_data_in;
              cap_rd    <= rd_in;
              cap_rw    <= reg_write_in;
              cap_m2r   <= mem_to_reg_in;
              cap_rd_en <= mem_read_in;
              cap_wr    <= mem_write_in;
            end
          end
          WAIT:    cnt <= cnt - CNT_W'(1);
          default: state <= IDLE;
        endcase
      end
    end
  end

`ifdef MEM_MISALIGN_CHECK_EN
  always_ff @(posedge clk) begin
    if (reset)                   misalign_out <= 1'b0;
    else if (!stall_flag_mem_in) misalign_out <= complete & mis;
  end
`endif
endmodule

// File: tb/tb_mem_access_stage.sv
// Directed bench for mem_access_stage (MEM_LATENCY=3); covers both builds of
// MEM_MISALIGN_CHECK_EN.
module tb_mem_access_stage;
  localparam int DEPTH = 256;
  localparam int ADDR_W = 8;
  localparam int LAT = 3;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        ex_valid = 1'b0;
  logic [31:0] alu_result_in = '0;
  logic [31:0] rs2_data_in = '0;
  logic [4:0]  rd_in = '0;
  logic        reg_write_in = 1'b0;
  logic        mem_to_reg_in = 1'b0;
  logic        mem_read_in = 1'b0;
  logic        mem_write_in = 1'b0;
  logic        stall_flag_mem_in = 1'b0;
  logic [31:0] alu_data_out, dm_data_out;
  logic [4:0]  rd_out_mem;
  logic        reg_write_out_mem, mem_to_reg_out, wb_valid, stall_flag_mem_out;
`ifdef MEM_MISALIGN_CHECK_EN
  logic        misalign_out;
`endif

  int checks = 0;
  int errors = 0;
  int cycles, stalls;
  logic [31:0] exp_q[$];
  logic [31:0] held_alu;

  mem_access_stage #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .MEM_LATENCY(LAT)) dut (
    .clk(clk), .reset(reset), .ex_valid(ex_valid),
    .alu_result_in(alu_result_in), .rs2_data_in(rs2_data_in), .rd_in(rd_in),
    .reg_write_in(reg_write_in), .mem_to_reg_in(mem_to_reg_in),
    .mem_read_in(mem_read_in), .mem_write_in(mem_write_in),
    .stall_flag_mem_in(stall_flag_mem_in),
    .alu_data_out(alu_data_out), .dm_data_out(dm_data_out),
    .rd_out_mem(rd_out_mem), .reg_write_out_mem(reg_write_out_mem),
    .mem_to_reg_out(mem_to_reg_out), .wb_valid(wb_valid),
    .stall_flag_mem_out(stall_flag_mem_out)
`ifdef MEM_MISALIGN_CHECK_EN
    , .misalign_out(misalign_out)
`endif
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one instruction, hold it until wb_valid (bounded), then drop it.
  task automatic exec(input logic [31:0] alu, input logic [31:0] rs2, input logic [4:0] rd,
                      input logic rw, input logic m2r, input logic rd_en, input logic wr);
    @(negedge clk);
    alu_result_in = alu; rs2_data_in = rs2; rd_in = rd;
    reg_write_in = rw; mem_to_reg_in = m2r; mem_read_in = rd_en; mem_write_in = wr;
    ex_valid = 1'b1;
    cycles = 0; stalls = 0;
    do begin
      tick();
      cycles++;
      if (stall_flag_mem_out) stalls++;
    end while (!wb_valid && cycles < 20);
    ex_valid = 1'b0;
    if (!wb_valid) check("wb_timeout", 32'(cycles), 32'(LAT));
  endtask

  task automatic store(input logic [31:0] addr, input logic [31:0] data);
    exec(addr, data, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic load(input string tag, input logic [31:0] addr, input logic [31:0] exp);
    exp_q.push_back(exp);
    exec(addr, 32'h0, 5'd7, 1'b1, 1'b1, 1'b1, 1'b0);
    check(tag, dm_data_out, exp_q.pop_front());
  endtask

  initial begin
    tick(); tick();
    reset = 1'b0;
    check("reset_wb_valid", {31'b0, wb_valid}, 32'h0);

    // ALU op: single-cycle, never stalls
    exec(32'hDEADBEEF, 32'h0, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0);
    check("alu_data", alu_data_out, 32'hDEADBEEF);
    check("alu_rd", {27'b0, rd_out_mem}, 32'd5);
    check("alu_rw", {31'b0, reg_write_out_mem}, 32'd1);
    check("alu_latency", 32'(cycles), 32'd1);
    check("alu_stalls", 32'(stalls), 32'd0);
    check("alu_dm_zero", dm_data_out, 32'h0);
    tick();
    check("wb_one_cycle", {31'b0, wb_valid}, 32'h0);
    check("bubble_rw_clr", {31'b0, reg_write_out_mem}, 32'h0);
    check("bubble_alu_hold", alu_data_out, 32'hDEADBEEF);

    // Store then load, latency 3
    store(32'h40, 32'h12345678);
    check("st_latency", 32'(cycles), 32'd3);
    check("st_stalls", 32'(stalls), 32'd2);
    check("st_dm_zero", dm_data_out, 32'h0);
    load("ld_after_st", 32'h40, 32'h12345678);
    check("ld_latency", 32'(cycles), 32'd3);
    check("ld_m2r", {31'b0, mem_to_reg_out}, 32'd1);

    // Address wrap modulo DEPTH
    store(32'(4 * DEPTH + 8), 32'h000000A5);
    load("wrap_ld", 32'h8, 32'h000000A5);

    // Read and write both set behaves as a store
    exec(32'h20, 32'hCAFEF00D, 5'd3, 1'b0, 1'b0, 1'b1, 1'b1);
    check("rw_both_dm", dm_data_out, 32'h0);
    load("rw_both_ld", 32'h20, 32'hCAFEF00D);

    // Downstream stall after completion holds wb_valid
    exec(32'h00000077, 32'h0, 5'd9, 1'b1, 1'b0, 1'b0, 1'b0);
    @(negedge clk); stall_flag_mem_in = 1'b1;
    tick();
    check("hold_wb_valid", {31'b0, wb_valid}, 32'h1);
    check("hold_stall_out", {31'b0, stall_flag_mem_out}, 32'h1);
    @(negedge clk); stall_flag_mem_in = 1'b0;
    tick();

    // Downstream stall 3 cycles during WAIT delays completion by 3
    held_alu = alu_data_out;
    @(negedge clk);
    alu_result_in = 32'h40; rd_in = 5'd11; reg_write_in = 1'b1; mem_to_reg_in = 1'b1;
    mem_read_in = 1'b1; mem_write_in = 1'b0; ex_valid = 1'b1;
    tick();
    @(negedge clk); stall_flag_mem_in = 1'b1;
    repeat (3) tick();
    check("frz_wb_valid", {31'b0, wb_valid}, 32'h0);
    check("frz_alu_hold", alu_data_out, held_alu);
    @(negedge clk); stall_flag_mem_in = 1'b0;
    cycles = 0;
    do begin tick(); cycles++; end while (!wb_valid && cycles < 20);
    ex_valid = 1'b0;
    check("frz_remaining", 32'(cycles), 32'd2);
    check("frz_ld_data", dm_data_out, 32'h12345678);

    // Misaligned load
`ifdef MEM_MISALIGN_CHECK_EN
    exec(32'h42, 32'h0, 5'd4, 1'b1, 1'b1, 1'b1, 1'b0);
    check("mis_flag", {31'b0, misalign_out}, 32'h1);
    check("mis_rw", {31'b0, reg_write_out_mem}, 32'h0);
    check("mis_dm", dm_data_out, 32'h0);
    tick();
    check("mis_pulse", {31'b0, misalign_out}, 32'h0);
`else
    load("unaligned_ld", 32'h42, 32'h12345678);
`endif

    // Reset mid-WAIT aborts store
    store(32'h10, 32'h11111111);
    @(negedge clk);
    alu_result_in = 32'h10; rs2_data_in = 32'h22222222; mem_write_in = 1'b1;
    mem_read_in = 1'b0; reg_write_in = 1'b0; ex_valid = 1'b1;
    tick();
    check("rst_pre_stall", {31'b0, stall_flag_mem_out}, 32'h1);
    @(negedge clk); reset = 1'b1; ex_valid = 1'b0; mem_write_in = 1'b0;
    tick(); tick();
    @(negedge clk); reset = 1'b0;
    check("rst_alu", alu_data_out, 32'h0);
    check("rst_dm", dm_data_out, 32'h0);
    check("rst_rd", {27'b0, rd_out_mem}, 32'h0);
    check("rst_ctl", {28'b0, reg_write_out_mem, mem_to_reg_out, wb_valid, stall_flag_mem_out}, 32'h0);
    load("rst_abort_ld", 32'h10, 32'h11111111);

    tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
